// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I fields into 32-bit instruction words and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module inst_encoder_loader #(
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm32,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic                last_q, last_nxt;
  logic                ready_nxt, we_nxt, busy_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [31:0]         wdata_nxt;
  logic [CNT_W-1:0]    count_nxt, count_inc;
  logic [31:0]         enc_c;
  logic                fmt_ok_c;

  // Field packing per instruction format; fmt 6/7 flagged illegal.
  always_comb begin
    enc_c    = '0;
    fmt_ok_c = 1'b1;
    case (fmt)
      3'd0: enc_c = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_c = {imm32[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_c = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
      3'd3: enc_c = {imm32[12], imm32[10:5], rs2, rs1, funct3,
                     imm32[4:1], imm32[11], opcode};
      3'd4: enc_c = {imm32[31:12], rd, opcode};
      3'd5: enc_c = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
      default: fmt_ok_c = 1'b0;
    endcase
  end

  assign count_inc = count + CNT_W'(1);

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    last_nxt  = last_q;
    ready_nxt = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    count_nxt = count;
    done_nxt  = done;
    err_nxt   = err;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          ptr_nxt   = '0;
          count_nxt = '0;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          ready_nxt = 1'b0;
          if (fmt_ok_c) begin
            wdata_nxt = enc_c;
            addr_nxt  = ADDR_W'(BASE_ADDR + ptr);
            last_nxt  = last;
            we_nxt    = 1'b1;
            state_nxt = S_WRITE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      S_WRITE: begin
        ptr_nxt   = ptr + ADDR_W'(1);
        count_nxt = count_inc;
        if (last_q) begin
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (count_inc == CNT_W'(DEPTH)) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          ready_nxt = 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_ACCEPT) || (state_nxt == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      last_q    <= last_nxt;
      in_ready  <= ready_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      count     <= count_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized self-checking bench for inst_encoder_loader against an arithmetic
// encoding model; small memory with non-zero base exercises wrap and overflow.
module tb_inst_encoder_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned BASE   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, in_valid, in_ready, last;
  logic [2:0]        fmt, funct3;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm32;
  logic              mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;
  int count_m  = 0;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(ADDR_W'(BASE))) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm32(imm32), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Instruction word built arithmetically from the format bit-placement rules.
  function automatic logic [31:0] enc_model(input int f, input int op, input int f3,
                                            input int f7, input int d, input int s1,
                                            input int s2, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op) + 32'(f3) * 32'h1000;
    case (f)
      0: w = w + 32'(d) * 128 + 32'(s1) * 32'h8000 + 32'(s2) * 32'h100000 + 32'(f7) * 32'h2000000;
      1: w = w + 32'(d) * 128 + 32'(s1) * 32'h8000 + (imm % 4096) * 32'h100000;
      2: w = w + (imm % 32) * 128 + 32'(s1) * 32'h8000 + 32'(s2) * 32'h100000
               + ((imm / 32) % 128) * 32'h2000000;
      3: w = w + ((imm / 2048) % 2) * 128 + ((imm / 2) % 16) * 256 + 32'(s1) * 32'h8000
               + 32'(s2) * 32'h100000 + ((imm / 32) % 64) * 32'h2000000
               + ((imm / 4096) % 2) * 32'h80000000;
      4: w = 32'(op) + 32'(d) * 128 + (imm / 4096) * 4096;
      default: w = 32'(op) + 32'(d) * 128 + ((imm / 4096) % 256) * 4096
                   + ((imm / 2048) % 2) * 32'h100000 + ((imm / 2) % 1024) * 32'h200000
                   + ((imm / 32'h100000) % 2) * 32'h80000000;
    endcase
    return w;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ptr_m = 0;
    count_m = 0;
    check("start_ready", 64'(in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_count", 64'(count), 64'd0);
    check("start_flags", 64'({done, err}), 64'd0);
  endtask

  // Offer one beat (optionally after idle gap), then check the write cycle and follow-up state.
  task automatic beat(input int f, input int op, input int f3, input int f7, input int d,
                      input int s1, input int s2, input logic [31:0] imm, input logic lst,
                      input logic [31:0] exp_word, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm32 = imm; last = lst;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    @(posedge clk); #1;
    // Fields only need to be stable in the handshake cycle.
    opcode = 7'($urandom); imm32 = $urandom; rd = 5'($urandom); fmt = 3'($urandom);
    last = 1'($urandom);
    if (f < 6) begin
      check("wr_we", 64'(mem_we), 64'd1);
      check("wr_addr", 64'(mem_addr), 64'((BASE + ptr_m) % DEPTH));
      check("wr_data", 64'(mem_wdata), 64'(exp_word));
      check("wr_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      ptr_m++;
      count_m++;
      check("we_pulse", 64'(mem_we), 64'd0);
      check("count", 64'(count), 64'(count_m));
      if (lst) begin
        check("done", 64'({done, busy, in_ready}), 64'b100);
      end else if (count_m == DEPTH) begin
        check("overflow", 64'({err, busy, in_ready}), 64'b100);
      end else begin
        check("next_ready", 64'({in_ready, busy, done, err}), 64'b1100);
      end
    end else begin
      check("illegal", 64'({mem_we, err, busy, in_ready}), 64'b0100);
    end
  endtask

  task automatic rand_beat(input logic lst, input int gap, output int f);
    int op, f3, f7, d, s1, s2;
    logic [31:0] imm;
    f  = ($urandom % 16 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
    op = int'($urandom % 128); f3 = int'($urandom % 8); f7 = int'($urandom % 128);
    d  = int'($urandom % 32); s1 = int'($urandom % 32); s2 = int'($urandom % 32);
    imm = $urandom;
    beat(f, op, f3, f7, d, s1, s2, imm, lst, enc_model(f, op, f3, f7, d, s1, s2, imm), gap);
  endtask

  initial begin
    int f;
    int len;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm32 = '0;
    #12;
    check("rst_outs", 64'({in_ready, mem_we, busy, done, err}), 64'd0);
    check("rst_bus", 64'({count, mem_addr, mem_wdata}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single R instruction program.
    do_start();
    beat(0, 'h33, 0, 0, 3, 1, 2, 32'd0, 1'b1, 32'h002081B3, 0);
    in_valid = 1'b0;

    // Back-to-back beats with in_valid held high across all formats.
    do_start();
    beat(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b0, 32'h00500093, 0);
    beat(2, 'h23, 2, 0, 0, 1, 2, 32'd8, 1'b0, 32'h0020A423, 0);
    beat(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000, 1'b0, 32'h123452B7, 0);
    beat(3, 'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3, 0);
    beat(5, 'h6F, 0, 0, 1, 0, 0, 32'd8, 1'b1, 32'h008000EF, 0);
    in_valid = 1'b0;

    // Illegal format, then restart writes from the base again.
    do_start();
    beat(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b0, 32'h00500093, 0);
    beat(7, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b0, 32'h0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("err_held", 64'({err, in_ready}), 64'b10);
    do_start();
    beat(0, 'h33, 0, 0, 3, 1, 2, 32'd0, 1'b1, 32'h002081B3, 0);
    in_valid = 1'b0;

    // start mid-ACCEPT must not reset pointer or count.
    do_start();
    rand_beat(1'b0, 0, f);
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("start_ignored", 64'({count, in_ready}), 64'({4'd1, 1'b1}));
    beat(1, 'h13, 0, 0, 7, 3, 0, 32'hABC, 1'b1, enc_model(1, 'h13, 0, 0, 7, 3, 0, 32'hABC), 0);
    in_valid = 1'b0;

    // Fill all of memory without last: wraps past the top, then flags overflow.
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      f = 6;
      while (f > 5) rand_beat(1'b0, int'($urandom % 2), f);
    end
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_nowrite", 64'({mem_we, in_ready, err}), 64'b001);
    end
    check("full_count", 64'(count), 64'(DEPTH));
    in_valid = 1'b0;

    // Random programs with occasional illegal formats and idle gaps.
    for (int p = 0; p < 25; p++) begin
      do_start();
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        rand_beat(i == len - 1, int'($urandom % 3), f);
        if (f > 5) break;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a write cycle.
    do_start();
    rand_beat(1'b0, 0, f);
    f = 6;
    in_valid = 1'b1; fmt = 3'd0; last = 1'b0;
    while (!in_ready) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("pre_rst_we", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 64'({mem_we, busy, in_ready, count}), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_rst", 64'({in_ready, busy, mem_we}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
